// File: rtl/tx_queue_arbiter_pkg.sv
// tx_queue_arbiter_pkg: shared arbiter state encoding and queue-count limit
package tx_queue_arbiter_pkg;
   typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_RELEASE} arb_state_t;
   localparam int max_tx_queues = 8;
endpackage

// File: rtl/tx_queue_arbiter_if.sv
// tx_queue_arbiter_if: queue-side and encapsulator-side signals of the TX queue arbiter
interface tx_queue_arbiter_if #(parameter int NUM_Q = 4);
   localparam int QW = $clog2(NUM_Q);
   logic [2*NUM_Q-1:0] q_buffer_ready;
   logic [8*NUM_Q-1:0] q_data;
   logic [NUM_Q-1:0]   q_r_en;
   logic [NUM_Q-1:0]   q_pct_txed;
   logic [1:0]         enc_buffer_ready;
   logic [7:0]         enc_data;
   logic               enc_r_en;
   logic               enc_pct_txed;
   logic               grant_valid;
   logic [QW-1:0]      grant_idx;
   modport master (
      output q_buffer_ready, q_data, enc_r_en, enc_pct_txed,
      input  q_r_en, q_pct_txed, enc_buffer_ready, enc_data, grant_valid, grant_idx
   );
   modport slave (
      input  q_buffer_ready, q_data, enc_r_en, enc_pct_txed,
      output q_r_en, q_pct_txed, enc_buffer_ready, enc_data, grant_valid, grant_idx
   );
endinterface

// File: rtl/tx_queue_arbiter_rr_picker.sv
// tx_rr_picker: first requesting index at or after ptr, wrapping modulo NUM_Q
module tx_rr_picker #(
   parameter  int NUM_Q = 4,
   localparam int QW    = $clog2(NUM_Q)
) (
   input  logic [NUM_Q-1:0] req,
   input  logic [QW-1:0]    ptr,
   output logic             any,
   output logic [QW-1:0]    idx
);
   // scan from farthest to nearest so the nearest hit is the last assignment
   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int k = NUM_Q - 1; k >= 0; k--)
         if (req[(int'(ptr) + k) % NUM_Q]) begin
            any = 1'b1;
            idx = QW'((int'(ptr) + k) % NUM_Q);
         end
   end
endmodule

// File: rtl/tx_queue_arbiter.sv
// tx_queue_arbiter: frame-locked grant of the encapsulator buffer port; TX_ARB_PRIO_EN selects strict priority
module tx_queue_arbiter
   import tx_queue_arbiter_pkg::*;
#(
   parameter  int NUM_Q = 4,
   localparam int QW    = $clog2(NUM_Q)
) (
   input logic eth_tx_clk,
   input logic rst,
   tx_queue_arbiter_if.slave bus
);
   if (NUM_Q < 2 || NUM_Q > max_tx_queues) begin : g_bad_num_q
      $error("tx_queue_arbiter: NUM_Q out of range");
   end
   arb_state_t state, state_d;
   logic [QW-1:0] grant_idx, grant_idx_d, rr_ptr, rr_ptr_d, pick_ptr, pick_idx, rr_next;
   logic [NUM_Q-1:0] req, pct_q, pct_d;
   logic pick_any, pct_prev, done, gv;
   for (genvar i = 0; i < NUM_Q; i++) begin : g_req
      assign req[i] = |bus.q_buffer_ready[2*i +: 2];
   end
`ifdef TX_ARB_PRIO_EN
   assign pick_ptr = '0;
   assign rr_next  = '0;
`else
   assign pick_ptr = rr_ptr;
   assign rr_next  = (grant_idx == QW'(NUM_Q - 1)) ? '0 : grant_idx + 1'b1;
`endif
   tx_rr_picker #(.NUM_Q(NUM_Q)) u_picker (
      .req(req),
      .ptr(pick_ptr),
      .any(pick_any),
      .idx(pick_idx)
   );
   assign gv   = state == ARB_GRANT;
   assign done = gv && bus.enc_pct_txed && !pct_prev;
   always_comb begin
      state_d     = state;
      grant_idx_d = grant_idx;
      rr_ptr_d    = rr_ptr;
      pct_d       = '0;
      if (state == ARB_IDLE && pick_any) begin
         state_d     = ARB_GRANT;
         grant_idx_d = pick_idx;
      end
      if (done) begin
         state_d  = ARB_RELEASE;
         rr_ptr_d = rr_next;
         pct_d    = NUM_Q'(1) << grant_idx;
      end
      if (state == ARB_RELEASE) state_d = ARB_IDLE;
   end
   always_ff @(posedge eth_tx_clk) begin
      if (rst) begin
         state     <= ARB_IDLE;
         grant_idx <= '0;
         rr_ptr    <= '0;
         pct_prev  <= 1'b0;
         pct_q     <= '0;
      end else begin
         state     <= state_d;
         grant_idx <= grant_idx_d;
         rr_ptr    <= rr_ptr_d;
         pct_prev  <= bus.enc_pct_txed;
         pct_q     <= pct_d;
      end
   end
   assign bus.grant_valid      = gv;
   assign bus.grant_idx        = grant_idx;
   assign bus.q_pct_txed       = pct_q;
   assign bus.enc_buffer_ready = gv ? bus.q_buffer_ready[2*grant_idx +: 2] : '0;
   assign bus.enc_data         = gv ? bus.q_data[8*grant_idx +: 8] : '0;
   assign bus.q_r_en           = (gv && bus.enc_r_en) ? NUM_Q'(1) << grant_idx : '0;
endmodule
